// File: rtl/csa_byte_sequencer_pkg.sv
// Shared types and constants for the byte-serial carry-select adder sequencer.
package csa_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BYTE_W = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csa_byte_sequencer_if.sv
// Operand-in / result-out handshake bundle for csa_byte_sequencer.
interface csa_byte_sequencer_if #(
    parameter int NUM_BYTES = 4
);
    import csa_seq_pkg::*;

    localparam int W = BYTE_W * NUM_BYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero
    );

endinterface

// File: rtl/csa_byte_sequencer_csa8.sv
// 8-bit carry-select adder: low nibble ripples, high nibble is
// precomputed for both carries and picked by the low carry-out.
module CSA_8bit (
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic       cin,
    output logic       out,
    output logic [7:0] sum
);

    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;
    logic [4:0] hi;

    assign lo  = {1'b0, in0[3:0]} + {1'b0, in1[3:0]} + {4'b0, cin};
    assign hi0 = {1'b0, in0[7:4]} + {1'b0, in1[7:4]};
    assign hi1 = {1'b0, in0[7:4]} + {1'b0, in1[7:4]} + 5'd1;
    assign hi  = lo[4] ? hi1 : hi0;

    assign sum = {hi[3:0], lo[3:0]};
    assign out = hi[4];

endmodule

// File: rtl/csa_byte_sequencer.sv
// Multi-cycle W-bit add/sub built from one 8-bit carry-select adder,
// processing one byte per clock, LSB first.
module csa_byte_sequencer
    import csa_seq_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    csa_byte_sequencer_if.slave      io
);

    localparam int W  = BYTE_W * NUM_BYTES;
    localparam int KW = idx_w(NUM_BYTES);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_BYTES - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [KW-1:0]   k_q, k_d;

    logic [7:0]      byte_a;
    logic [7:0]      byte_b;
    logic [7:0]      byte_s;
    logic            byte_c;

    assign byte_a = a_q[BYTE_W*k_q +: BYTE_W];
    assign byte_b = b_q[BYTE_W*k_q +: BYTE_W];

    CSA_8bit u_csa (
        .in0 (byte_a),
        .in1 (byte_b),
        .cin (carry_q),
        .out (byte_c),
        .sum (byte_s)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    a_d     = io.a;
                    b_d     = io.sub ? ~io.b : io.b;
                    // subtract is a + ~b + 1 - borrow_in
                    carry_d = io.cin ^ io.sub;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[BYTE_W*k_q +: BYTE_W] = byte_s;
                carry_d = byte_c;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic done;
    assign done = (state_q == DONE);

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = done;
    assign io.sum       = sum_q;
    assign io.cout      = done & carry_q;
    assign io.overflow  = done & (a_q[W-1] == b_q[W-1])
                               & (sum_q[W-1] != a_q[W-1]);
    assign io.zero      = done & (sum_q == '0);

endmodule

// File: tb/tb_csa_byte_sequencer.sv
// Directed bench for csa_byte_sequencer with NUM_BYTES=4.
module tb_csa_byte_sequencer;

    localparam int NB = 4;

    logic clock;
    logic reset_n;
    int   n_chk;
    int   n_bad;

    csa_byte_sequencer_if #(.NUM_BYTES(NB)) io ();

    csa_byte_sequencer #(.NUM_BYTES(NB)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .io      (io.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, ".in_ready"}, 64'(io.in_ready), 64'd1);
        check({tag, ".out_valid"}, 64'(io.out_valid), 64'd0);
        check({tag, ".sum"}, 64'(io.sum), 64'd0);
        check({tag, ".cout"}, 64'(io.cout), 64'd0);
        check({tag, ".ovf"}, 64'(io.overflow), 64'd0);
        check({tag, ".zero"}, 64'(io.zero), 64'd0);
    endtask

    // drive at negedge, acceptance happens at the following posedge
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
        int n;
        n = 0;
        while (!io.in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("issue.in_ready", 64'(io.in_ready), 64'd1);
        io.a        = a;
        io.b        = b;
        io.cin      = cin;
        io.sub      = sub;
        io.in_valid = 1'b1;
        @(negedge clock);
        io.in_valid = 1'b0;
        io.a        = 32'hDEAD_BEEF;
        io.b        = 32'h1234_5678;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!io.out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic consume();
        io.out_ready = 1'b1;
        @(negedge clock);
        io.out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic cin,
                          input logic sub, input logic [31:0] s,
                          input logic co, input logic ov,
                          input logic z);
        int lat;
        issue(a, b, cin, sub);
        wait_result(lat);
        check({tag, ".lat"}, 64'(lat), 64'd4);
        check({tag, ".sum"}, 64'(io.sum), 64'(s));
        check({tag, ".cout"}, 64'(io.cout), 64'(co));
        check({tag, ".ovf"}, 64'(io.overflow), 64'(ov));
        check({tag, ".zero"}, 64'(io.zero), 64'(z));
        consume();
        check({tag, ".idle"}, 64'(io.in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        n_chk        = 0;
        n_bad        = 0;
        reset_n      = 1'b0;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        io.a         = '0;
        io.b         = '0;
        io.cin       = 1'b0;
        io.sub       = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_reset_outs("rst");

        run_op("add", 32'h0000_008C, 32'h0000_000C, 1'b0, 1'b0,
               32'h0000_0098, 1'b0, 1'b0, 1'b0);
        run_op("chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
               32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op("chain84", 32'h8484_8484, 32'h8484_8484, 1'b1, 1'b0,
               32'h0909_0909, 1'b1, 1'b1, 1'b0);
        run_op("sub57", 32'd5, 32'd7, 1'b0, 1'b1,
               32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub75", 32'd7, 32'd5, 1'b1, 1'b1,
               32'h0000_0001, 1'b1, 1'b0, 1'b0);
        run_op("ovfadd", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0,
               32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op("ovfsub", 32'h8000_0000, 32'd1, 1'b0, 1'b1,
               32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // stall in DONE with stray in_valid pulses
        issue(32'h0000_1234, 32'h0000_0101, 1'b0, 1'b0);
        wait_result(lat);
        check("stall.lat", 64'(lat), 64'd4);
        held = 32'h0000_1335;
        for (int i = 0; i < 10; i++) begin
            io.in_valid = i[0];
            io.a        = 32'hFFFF_0000 + 32'(i);
            @(negedge clock);
            check("stall.valid", 64'(io.out_valid), 64'd1);
            check("stall.in_ready", 64'(io.in_ready), 64'd0);
            check("stall.sum", 64'(io.sum), 64'(held));
        end

        // consume and offer new operands in the same cycle
        io.a         = 32'h0000_0010;
        io.b         = 32'h0000_0020;
        io.cin       = 1'b0;
        io.sub       = 1'b0;
        io.in_valid  = 1'b1;
        io.out_ready = 1'b1;
        @(negedge clock);
        io.out_ready = 1'b0;
        check("ovl.out_valid", 64'(io.out_valid), 64'd0);
        check("ovl.in_ready", 64'(io.in_ready), 64'd1);
        @(negedge clock);
        io.in_valid = 1'b0;
        check("ovl.accepted", 64'(io.in_ready), 64'd0);
        wait_result(lat);
        check("ovl.lat", 64'(lat), 64'd4);
        check("ovl.sum", 64'(io.sum), 64'h30);
        consume();

        // reset while byte 2 is in flight
        issue(32'h0102_0304, 32'h0506_0708, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        @(negedge clock);
        reset_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (io.out_valid) lat++;
        end
        check("midrst.no_valid", 64'(lat), 64'd0);
        check_reset_outs("midrst.after");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/csa_byte_sequencer.md
# csa_byte_sequencer

Multi-cycle adder/subtractor controller that reuses one 8-bit carry-select adder (`CSA_8bit`) to add or subtract `NUM_BYTES`-byte operands, one byte per clock, least-significant byte first. The byte carry is rippled through a register between cycles. The block sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It is the area-saving alternative to a full-width adder in the ALU datapath.

## Interface
- `NUM_BYTES`, default 4: operand width in bytes (≥1); data width `W = 8*NUM_BYTES`.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand request valid.
- `in_ready`  out  1  block can accept operands.
- `a`, `b`  in  W  operands.
- `cin`  in  1  carry-in when adding; borrow-in when subtracting.
- `sub`  in  1  0 = `a+b+cin`, 1 = `a-b-cin`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  W  result.
- `cout`  out  1  carry-out of MSB (for subtract: 1 = no borrow).
- `overflow`  out  1  signed overflow.
- `zero`  out  1  `sum == 0`.

## Operation
- **States:** `IDLE`, `RUN`, `DONE`.
- **IDLE:** `in_ready=1`. When `in_valid` is high, latch:
  - `a`
  - `b_eff = sub ? ~b : b`
  - `sub`
  - `carry = cin ^ sub`
  - byte index `k = 0`
  
  Then go to `RUN`.
- **RUN:** each cycle, drive `CSA_8bit` with `a[8k+:8]`, `b_eff[8k+:8]`, and `carry`.
  - Write its sum to `sum[8k+:8]` and its carry-out to `carry`.
  - If `k == NUM_BYTES-1`, go to `DONE`. Otherwise `k = k+1`.
- **DONE:** `out_valid=1`.
  - `cout = carry`.
  - `overflow = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1])`.
  - `zero = (sum == 0)`.
  - On `out_ready`, go to `IDLE`.
- **Stability:** `sum`, `cout`, `overflow`, `zero` are undefined-free and stable throughout `DONE`. They are only required to be meaningful while `out_valid=1`.
- **Input timing:** `in_ready=0` in `RUN` and `DONE`. Inputs are ignored there and may change freely after acceptance.
- **No overlap:** in `DONE`, with `out_ready=1` and `in_valid=1` in the same cycle, the result is consumed but the new operands are not accepted. The earliest acceptance is the next cycle, in `IDLE`.
- **Reset value of every output:** `in_ready=1` (state `IDLE`), `out_valid=0`, `sum=0`, `cout=0`, `overflow=0`, `zero=0`.
- **Reset mid-operation:** asserting `reset_n=0` in any state immediately returns to `IDLE`. All registers clear and the partial result is discarded.
- **Width rule:** all arithmetic is modulo 2^W. No extra sign-extension bit is kept.

## Timing
- Acceptance edge is E0; byte `k` is computed and registered at edge E(k+1).
- `out_valid` rises after edge E(NUM_BYTES) and stays high until the edge where `out_ready=1` is sampled.
- Latency is `NUM_BYTES` cycles from acceptance to `out_valid`. Minimum issue interval is `NUM_BYTES+2` cycles.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- The `CSA_8bit` path plus the carry-register setup must fit in one `clock` period. This is the only combinational adder path.

## Structure
- **Package `csa_seq_pkg`:**
  - state enum (`IDLE`, `RUN`, `DONE`)
  - `BYTE_W = 8`
  - byte-index width function `clog2(NUM_BYTES)`, minimum 1
- **Sub-module:** exactly one `CSA_8bit` instance, port order `(in0, in1, cin, out, sum)`. No other sub-modules.
- **Registers:** `a`, `b_eff`, `sum`, `carry`, `k`, `state`.

## Test plan
All scenarios use `NUM_BYTES=4`.
- **Reset:** hold `reset_n=0` for 3 cycles, then release → `in_ready=1`, `out_valid=0`, `sum=0`, `cout=0`, `overflow=0`, `zero=0`.
- **Basic add, with latency check:** `a=0x0000008C`, `b=0x0000000C`, `cin=0`, `sub=0` → exactly 4 cycles after acceptance, `out_valid=1`, `sum=0x00000098`, `cout=0`, `zero=0`.
- **Full carry chain:** `a=0xFFFFFFFF`, `b=0x00000001`, `cin=0` → `sum=0x00000000`, `cout=1`, `zero=1`, `overflow=0`. Repeat with `a=b=0x84848484`, `cin=1` → `sum=0x09090909`, `cout=1`.
- **Subtract:**
  - `a=5`, `b=7`, `sub=1`, `cin=0` → `sum=0xFFFFFFFE`, `cout=0`, `overflow=0`.
  - `a=7`, `b=5`, `sub=1`, `cin=1` → `sum=0x00000001`, `cout=1`.
- **Signed overflow:**
  - `a=0x7FFFFFFF`, `b=1`, add → `sum=0x80000000`, `overflow=1`.
  - `a=0x80000000`, `b=1`, `sub=1` → `sum=0x7FFFFFFF`, `overflow=1`.
- **Handshake and reset boundaries:**
  - Hold `out_ready=0` for 10 cycles in `DONE` → outputs stable, `in_ready=0`, and `in_valid` pulses are ignored.
  - Assert `out_ready` and `in_valid` together → result consumed, new operands accepted on the following cycle.
  - Assert `reset_n=0` during `RUN` at `k=2` → block is in `IDLE` with all outputs at reset values, and no `out_valid` appears.
